// File: rtl/ascon_permutation.sv
// Iterative ASCON permutation p^n (n = 1..12), one round per clock edge.
// Define ASCON_PERM_UNROLL2_EN to apply two rounds per busy edge.
package ascon_pkg;
  localparam int unsigned STATE_W    = 320;
  localparam int unsigned WORD_W     = 64;
  localparam int unsigned MAX_ROUNDS = 12;

  // Entries 12..15 are padding so a 4-bit counter can index without range issues.
  localparam logic [7:0] C_LUT_ADDITION [16] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5, 8'h96, 8'h87,
    8'h78, 8'h69, 8'h5a, 8'h4b, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [4:0] C_LUT_SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
endpackage

module ascon_permutation
  import ascon_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic [3:0]         i_rounds,
  input  logic [STATE_W-1:0] i_state,
  output logic               o_busy,
  output logic               o_done,
  output logic [STATE_W-1:0] o_state
);

  localparam int unsigned CTR_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [CTR_W-1:0]   ctr_inc_c;
  logic [CTR_W-1:0]   n_sat_c;
  logic [STATE_W-1:0] data_d;
  logic [STATE_W-1:0] round_c;
  logic               done_d;
  logic               last_c;

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // One full round: constant addition, S-box layer, linear diffusion.
  function automatic logic [STATE_W-1:0] ascon_round(input logic [STATE_W-1:0] s,
                                                      input logic [7:0]         c);
    logic [WORD_W-1:0] x [5];
    logic [WORD_W-1:0] y [5];
    logic [4:0]        idx;
    logic [4:0]        sb;
    x[0] = s[319:256];
    x[1] = s[255:192];
    x[2] = s[191:128];
    x[3] = s[127:64];
    x[4] = s[63:0];
    x[2][7:0] = x[2][7:0] ^ c;
    for (int j = 0; j < int'(WORD_W); j++) begin
      idx     = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
      sb      = C_LUT_SBOX[idx];
      y[0][j] = sb[4];
      y[1][j] = sb[3];
      y[2][j] = sb[2];
      y[3][j] = sb[1];
      y[4][j] = sb[0];
    end
    x[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
    x[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
    x[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
    x[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
    x[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

`ifdef ASCON_PERM_UNROLL2_EN
  logic [STATE_W-1:0] one_c;

  // Odd counter means odd n: take a single round first so pairs end exactly at 12.
  always_comb begin
    one_c = ascon_round(o_state, C_LUT_ADDITION[ctr_q]);
    if (ctr_q[0]) begin
      round_c   = one_c;
      ctr_inc_c = ctr_q + CTR_W'(1);
    end else begin
      round_c   = ascon_round(one_c, C_LUT_ADDITION[ctr_q + CTR_W'(1)]);
      ctr_inc_c = ctr_q + CTR_W'(2);
    end
  end
`else
  assign round_c   = ascon_round(o_state, C_LUT_ADDITION[ctr_q]);
  assign ctr_inc_c = ctr_q + CTR_W'(1);
`endif

  assign last_c  = (ctr_inc_c == CTR_W'(MAX_ROUNDS));
  assign n_sat_c = (i_rounds > CTR_W'(MAX_ROUNDS)) ? CTR_W'(MAX_ROUNDS) : i_rounds;

  // Next-state and datapath selection.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    data_d  = o_state;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          data_d = i_state;
          if (n_sat_c == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_BUSY;
            ctr_d   = CTR_W'(MAX_ROUNDS) - n_sat_c;
          end
        end
      end
      ST_BUSY: begin
        data_d = round_c;
        ctr_d  = ctr_inc_c;
        if (last_c) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ctr_q   <= '0;
      o_state <= '0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      o_state <= data_d;
      o_done  <= done_d;
    end
  end

  assign o_busy = (state_q == ST_BUSY);

endmodule
